// File: rtl/ex_cdb_pipe.sv
// ex_cdb_pipe: latency-indexed completion slots that feed the common data bus.
// An op is loaded at slot L-1, shifts toward slot 0 on advancing cycles, and broadcasts from slot 0.
`ifndef FU_SEL_W
`define FU_SEL_W 3
`endif
`ifndef FU_SEL_NONE
`define FU_SEL_NONE 3'd0
`endif
`ifndef FU_SEL_ALU
`define FU_SEL_ALU 3'd1
`endif
`ifndef FU_SEL_UNCOND_BRANCH
`define FU_SEL_UNCOND_BRANCH 3'd2
`endif
`ifndef FU_SEL_COND_BRANCH
`define FU_SEL_COND_BRANCH 3'd3
`endif
`ifndef FU_SEL_LOAD
`define FU_SEL_LOAD 3'd4
`endif
`ifndef FU_SEL_STORE
`define FU_SEL_STORE 3'd5
`endif
`ifndef FU_SEL_MULT
`define FU_SEL_MULT 3'd6
`endif
`ifndef PRF_IDX_W
`define PRF_IDX_W 6
`endif
`ifndef ROB_IDX_W
`define ROB_IDX_W 5
`endif
`ifndef BR_MASK_W
`define BR_MASK_W 4
`endif

module ex_cdb_pipe #(
    parameter int EX_CYCLES_MAX = 4,
    parameter int LAT_ALU       = 1,
    parameter int LAT_BRANCH    = 1,
    parameter int LAT_LOAD      = 2,
    parameter int LAT_STORE     = 1,
    parameter int LAT_MULT      = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   iss_vld_i,
    input  logic [`FU_SEL_W-1:0]                   iss_fu_sel_i,
    input  logic [`PRF_IDX_W-1:0]                  iss_dest_tag_i,
    input  logic [`ROB_IDX_W:0]                    iss_rob_idx_i,
    input  logic [`BR_MASK_W-1:0]                  iss_br_mask_i,
    input  logic                                   stall_i,
    input  logic                                   rob_br_pred_correct_i,
    input  logic                                   rob_br_recovery_i,
    input  logic [`BR_MASK_W-1:0]                  rob_br_tag_fix_i,
    output logic                                   cdb_vld_o,
    output logic [`PRF_IDX_W-1:0]                  cdb_tag_o,
    output logic [`ROB_IDX_W:0]                    cdb_rob_idx_o,
    output logic [`BR_MASK_W-1:0]                  cdb_br_mask_o,
    output logic [$clog2(EX_CYCLES_MAX+1)-1:0]     inflight_o,
    output logic                                   sched_err_o
);
    localparam int N      = EX_CYCLES_MAX;
    localparam int CNT_W  = $clog2(EX_CYCLES_MAX + 1);
    localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;
    localparam int TAG_W  = `PRF_IDX_W;
    localparam int ROB_W  = `ROB_IDX_W + 1;
    localparam int MASK_W = `BR_MASK_W;

    logic [N-1:0]              r_vld;
    logic [N-1:0][TAG_W-1:0]   r_tag;
    logic [N-1:0][ROB_W-1:0]   r_rob;
    logic [N-1:0][MASK_W-1:0]  r_mask;
    logic [CNT_W-1:0]          r_inflight;
    logic                      r_sched_err;

    logic [N-1:0]              w_nxt_vld;
    logic [N-1:0][TAG_W-1:0]   w_nxt_tag;
    logic [N-1:0][ROB_W-1:0]   w_nxt_rob;
    logic [N-1:0][MASK_W-1:0]  w_nxt_mask;
    logic [N-1:0]              w_ld_here;
    logic [N-1:0]              w_coll;
    logic [CNT_W-1:0]          w_nxt_cnt;
    logic                      w_adv;
    logic                      w_accept;
    logic [MASK_W-1:0]         w_keep;
    logic [IDX_W-1:0]          w_load_idx;
    int                        w_lat;

    assign w_adv    = ~stall_i & ~rob_br_recovery_i;
    assign w_accept = iss_vld_i & w_adv & (iss_fu_sel_i != `FU_SEL_NONE);
    // A correct prediction retires the resolving bit from every mask, incoming op included.
    assign w_keep   = rob_br_pred_correct_i ? ~rob_br_tag_fix_i : {MASK_W{1'b1}};

    always_comb begin
        w_lat = N;
        case (iss_fu_sel_i)
            `FU_SEL_ALU:           w_lat = LAT_ALU;
            `FU_SEL_UNCOND_BRANCH: w_lat = LAT_BRANCH;
            `FU_SEL_COND_BRANCH:   w_lat = LAT_BRANCH;
            `FU_SEL_LOAD:          w_lat = LAT_LOAD;
            `FU_SEL_STORE:         w_lat = LAT_STORE;
            `FU_SEL_MULT:          w_lat = LAT_MULT;
            default:               w_lat = N;
        endcase
    end

    assign w_load_idx = IDX_W'(w_lat - 1);

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_slot
            logic              w_up_vld;
            logic [TAG_W-1:0]  w_up_tag;
            logic [ROB_W-1:0]  w_up_rob;
            logic [MASK_W-1:0] w_up_mask;
            logic              w_squash;

            if (gi == N - 1) begin : g_top
                assign w_up_vld  = 1'b0;
                assign w_up_tag  = '0;
                assign w_up_rob  = '0;
                assign w_up_mask = '0;
            end else begin : g_mid
                assign w_up_vld  = r_vld[gi+1];
                assign w_up_tag  = r_tag[gi+1];
                assign w_up_rob  = r_rob[gi+1];
                assign w_up_mask = r_mask[gi+1];
            end

            assign w_ld_here[gi] = w_accept && (w_load_idx == IDX_W'(gi));
            assign w_squash      = |(r_mask[gi] & rob_br_tag_fix_i);
            // The incoming op overwrites whatever would have shifted into its slot.
            assign w_coll[gi]    = w_ld_here[gi] & w_up_vld;

            assign w_nxt_vld[gi]  = rob_br_recovery_i ? (r_vld[gi] & ~w_squash) :
                                    !w_adv            ? r_vld[gi] :
                                                        (w_ld_here[gi] | w_up_vld);
            assign w_nxt_tag[gi]  = !w_adv ? r_tag[gi] :
                                    w_ld_here[gi] ? iss_dest_tag_i : w_up_tag;
            assign w_nxt_rob[gi]  = !w_adv ? r_rob[gi] :
                                    w_ld_here[gi] ? iss_rob_idx_i : w_up_rob;
            assign w_nxt_mask[gi] = rob_br_recovery_i ? r_mask[gi] :
                                    ((!w_adv ? r_mask[gi] :
                                      w_ld_here[gi] ? iss_br_mask_i : w_up_mask) & w_keep);
        end
    endgenerate

    always_comb begin
        w_nxt_cnt = '0;
        for (int i = 0; i < N; i++) begin
            w_nxt_cnt = w_nxt_cnt + CNT_W'(w_nxt_vld[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld       <= '0;
            r_tag       <= '0;
            r_rob       <= '0;
            r_mask      <= '0;
            r_inflight  <= '0;
            r_sched_err <= 1'b0;
        end else begin
            r_vld      <= w_nxt_vld;
            r_tag      <= w_nxt_tag;
            r_rob      <= w_nxt_rob;
            r_mask     <= w_nxt_mask;
            r_inflight <= w_nxt_cnt;
            if (|w_coll) begin
                r_sched_err <= 1'b1;
            end
        end
    end

    // Gating with adv keeps a held slot 0 from broadcasting more than once.
    assign cdb_vld_o     = r_vld[0] & w_adv;
    assign cdb_tag_o     = r_tag[0];
    assign cdb_rob_idx_o = r_rob[0];
    assign cdb_br_mask_o = r_mask[0];
    assign inflight_o    = r_inflight;
    assign sched_err_o   = r_sched_err;

endmodule

// File: tb/tb_ex_cdb_pipe.sv
// Bench for ex_cdb_pipe: a queue-of-ops model with countdowns is checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
`ifndef FU_SEL_W
`define FU_SEL_W 3
`endif
`ifndef FU_SEL_NONE
`define FU_SEL_NONE 3'd0
`endif
`ifndef FU_SEL_ALU
`define FU_SEL_ALU 3'd1
`endif
`ifndef FU_SEL_UNCOND_BRANCH
`define FU_SEL_UNCOND_BRANCH 3'd2
`endif
`ifndef FU_SEL_COND_BRANCH
`define FU_SEL_COND_BRANCH 3'd3
`endif
`ifndef FU_SEL_LOAD
`define FU_SEL_LOAD 3'd4
`endif
`ifndef FU_SEL_STORE
`define FU_SEL_STORE 3'd5
`endif
`ifndef FU_SEL_MULT
`define FU_SEL_MULT 3'd6
`endif
`ifndef PRF_IDX_W
`define PRF_IDX_W 6
`endif
`ifndef ROB_IDX_W
`define ROB_IDX_W 5
`endif
`ifndef BR_MASK_W
`define BR_MASK_W 4
`endif

module tb_ex_cdb_pipe;
    logic                   clk = 1'b0;
    logic                   rst;
    logic                   iss_vld_i;
    logic [`FU_SEL_W-1:0]   iss_fu_sel_i;
    logic [`PRF_IDX_W-1:0]  iss_dest_tag_i;
    logic [`ROB_IDX_W:0]    iss_rob_idx_i;
    logic [`BR_MASK_W-1:0]  iss_br_mask_i;
    logic                   stall_i;
    logic                   rob_br_pred_correct_i;
    logic                   rob_br_recovery_i;
    logic [`BR_MASK_W-1:0]  rob_br_tag_fix_i;
    logic                   cdb_vld_o;
    logic [`PRF_IDX_W-1:0]  cdb_tag_o;
    logic [`ROB_IDX_W:0]    cdb_rob_idx_o;
    logic [`BR_MASK_W-1:0]  cdb_br_mask_o;
    logic [2:0]             inflight_o;
    logic                   sched_err_o;

    always #5 clk = ~clk;

    ex_cdb_pipe #(
        .EX_CYCLES_MAX(4), .LAT_ALU(1), .LAT_BRANCH(1),
        .LAT_LOAD(2), .LAT_STORE(1), .LAT_MULT(4)
    ) dut (
        .clk(clk), .rst(rst),
        .iss_vld_i(iss_vld_i), .iss_fu_sel_i(iss_fu_sel_i),
        .iss_dest_tag_i(iss_dest_tag_i), .iss_rob_idx_i(iss_rob_idx_i),
        .iss_br_mask_i(iss_br_mask_i), .stall_i(stall_i),
        .rob_br_pred_correct_i(rob_br_pred_correct_i),
        .rob_br_recovery_i(rob_br_recovery_i), .rob_br_tag_fix_i(rob_br_tag_fix_i),
        .cdb_vld_o(cdb_vld_o), .cdb_tag_o(cdb_tag_o), .cdb_rob_idx_o(cdb_rob_idx_o),
        .cdb_br_mask_o(cdb_br_mask_o), .inflight_o(inflight_o), .sched_err_o(sched_err_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: each in-flight op counts down the advancing edges left before it is on the bus.
    typedef struct {
        logic [5:0] tag;
        logic [5:0] rob;
        logic [3:0] mask;
        int         rem;
    } op_t;

    op_t mq[$];
    bit  m_err   = 1'b0;
    bit  m_known = 1'b0;

    function automatic int lat_of(input logic [2:0] f);
        case (f)
            `FU_SEL_ALU:           return 1;
            `FU_SEL_UNCOND_BRANCH: return 1;
            `FU_SEL_COND_BRANCH:   return 1;
            `FU_SEL_LOAD:          return 2;
            `FU_SEL_STORE:         return 1;
            `FU_SEL_MULT:          return 4;
            default:               return 4;
        endcase
    endfunction

    always @(posedge clk) begin
        op_t nq[$];
        op_t o;
        int  r;
        nq = {};
        if (rst) begin
            mq = {};
            m_err = 1'b0;
            m_known = 1'b1;
        end else if (rob_br_recovery_i) begin
            foreach (mq[i]) if ((mq[i].mask & rob_br_tag_fix_i) == 4'b0) nq.push_back(mq[i]);
            mq = nq;
        end else begin
            if (rob_br_pred_correct_i)
                foreach (mq[i]) mq[i].mask = mq[i].mask & ~rob_br_tag_fix_i;
            if (!stall_i) begin
                foreach (mq[i]) begin
                    if (mq[i].rem > 0) begin
                        o = mq[i];
                        o.rem = o.rem - 1;
                        nq.push_back(o);
                    end
                end
                if (iss_vld_i && iss_fu_sel_i != `FU_SEL_NONE) begin
                    r = lat_of(iss_fu_sel_i) - 1;
                    mq = nq;
                    nq = {};
                    foreach (mq[i]) begin
                        if (mq[i].rem == r) m_err = 1'b1;
                        else nq.push_back(mq[i]);
                    end
                    o.tag  = iss_dest_tag_i;
                    o.rob  = iss_rob_idx_i;
                    o.mask = iss_br_mask_i & ~(rob_br_pred_correct_i ? rob_br_tag_fix_i : 4'b0);
                    o.rem  = r;
                    nq.push_back(o);
                end
                mq = nq;
            end
        end
    end

    always @(negedge clk) begin
        bit  e_has;
        bit  e_vld;
        op_t e_op;
        if (m_known) begin
            e_has = 1'b0;
            foreach (mq[i]) begin
                if (mq[i].rem == 0) begin
                    e_has = 1'b1;
                    e_op  = mq[i];
                end
            end
            e_vld = e_has && !stall_i && !rob_br_recovery_i;
            check("model_cdb_vld", 32'(cdb_vld_o), 32'(e_vld));
            if (e_vld) begin
                check("model_cdb_tag", 32'(cdb_tag_o), 32'(e_op.tag));
                check("model_cdb_rob", 32'(cdb_rob_idx_o), 32'(e_op.rob));
                check("model_cdb_mask", 32'(cdb_br_mask_o), 32'(e_op.mask));
            end
            check("model_inflight", 32'(inflight_o), 32'(mq.size()));
            check("model_sched_err", 32'(sched_err_o), 32'(m_err));
            if (cdb_vld_o)
                $display("[TB] t=%0t cdb tag=%0d rob=%0d mask=%b", $time,
                         cdb_tag_o, cdb_rob_idx_o, cdb_br_mask_o);
        end
    end

    task automatic quiet();
        iss_vld_i = 1'b0; iss_fu_sel_i = '0; iss_dest_tag_i = '0;
        iss_rob_idx_i = '0; iss_br_mask_i = '0; stall_i = 1'b0;
        rob_br_pred_correct_i = 1'b0; rob_br_recovery_i = 1'b0; rob_br_tag_fix_i = '0;
    endtask

    task automatic issue(input logic [2:0] fu, input logic [5:0] tag,
                         input logic [5:0] rob, input logic [3:0] mask);
        iss_vld_i = 1'b1; iss_fu_sel_i = fu; iss_dest_tag_i = tag;
        iss_rob_idx_i = rob; iss_br_mask_i = mask;
    endtask

    // Close the current cycle: go to the next active edge, then release inputs.
    task automatic endc();
        @(posedge clk);
        #1;
        quiet();
    endtask

    task automatic lit_cdb(input string nm, input bit v, input int tag, input int mask);
        check({nm, "_vld"}, 32'(cdb_vld_o), 32'(v));
        if (v) begin
            check({nm, "_tag"}, 32'(cdb_tag_o), 32'(tag));
            check({nm, "_mask"}, 32'(cdb_br_mask_o), 32'(mask));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        quiet();
        rst = 1'b1;
        endc();
        endc();
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_vld", 32'(cdb_vld_o), 0);
        check("rst_tag", 32'(cdb_tag_o), 0);
        check("rst_rob", 32'(cdb_rob_idx_o), 0);
        check("rst_mask", 32'(cdb_br_mask_o), 0);
        check("rst_inflight", 32'(inflight_o), 0);
        check("rst_err", 32'(sched_err_o), 0);
        endc();

        // Single ALU op: tag 7, rob 5, one broadcast the next cycle
        issue(`FU_SEL_ALU, 6'd7, 6'd5, 4'b0);
        @(negedge clk); check("alu_inflight0", 32'(inflight_o), 0); endc();
        @(negedge clk); lit_cdb("alu_bcast", 1'b1, 7, 0);
        check("alu_rob", 32'(cdb_rob_idx_o), 5);
        check("alu_inflight1", 32'(inflight_o), 1); endc();
        @(negedge clk); lit_cdb("alu_after", 1'b0, 0, 0);
        check("alu_inflight2", 32'(inflight_o), 0); endc();

        // Stall delays the broadcast; the bundle offered under stall is dropped
        issue(`FU_SEL_ALU, 6'd10, 6'd1, 4'b0);
        @(negedge clk); endc();
        stall_i = 1'b1; issue(`FU_SEL_ALU, 6'd11, 6'd2, 4'b0);
        @(negedge clk); lit_cdb("stall_hold", 1'b0, 0, 0); endc();
        @(negedge clk); lit_cdb("stall_release", 1'b1, 10, 0); endc();
        @(negedge clk); lit_cdb("stall_dropped", 1'b0, 0, 0);
        check("stall_inflight", 32'(inflight_o), 0); endc();

        // MULT@1, LOAD@2, ALU@4: ALU collides with the MULT arriving at slot 0
        issue(`FU_SEL_MULT, 6'd3, 6'd3, 4'b0);
        @(negedge clk); endc();
        issue(`FU_SEL_LOAD, 6'd4, 6'd4, 4'b0);
        @(negedge clk); endc();
        @(negedge clk); check("mix_inflight", 32'(inflight_o), 2); endc();
        issue(`FU_SEL_ALU, 6'd5, 6'd6, 4'b0);
        @(negedge clk); lit_cdb("mix_load", 1'b1, 4, 0);
        check("mix_err_before", 32'(sched_err_o), 0); endc();
        @(negedge clk); lit_cdb("mix_alu", 1'b1, 5, 0);
        check("mix_err_set", 32'(sched_err_o), 1); endc();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); check("mix_err_sticky", 32'(sched_err_o), 1); endc();
        end

        rst = 1'b1;
        @(negedge clk); endc();
        rst = 1'b0;
        @(negedge clk); check("rst_err_clear", 32'(sched_err_o), 0); endc();

        // Recovery squashes MULT (mask 0010); LOAD (mask 0001) slips one cycle
        issue(`FU_SEL_MULT, 6'd20, 6'd8, 4'b0010);
        @(negedge clk); endc();
        issue(`FU_SEL_LOAD, 6'd21, 6'd9, 4'b0001);
        @(negedge clk); endc();
        rob_br_recovery_i = 1'b1; rob_br_tag_fix_i = 4'b0010;
        @(negedge clk); check("rec_inflight_before", 32'(inflight_o), 2); endc();
        @(negedge clk); check("rec_inflight_after", 32'(inflight_o), 1);
        lit_cdb("rec_gap", 1'b0, 0, 0); endc();
        @(negedge clk); lit_cdb("rec_load", 1'b1, 21, 1); endc();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); lit_cdb("rec_no_mult", 1'b0, 0, 0); endc();
        end

        // Correct prediction clears bit 0 in flight and on the incoming op
        issue(`FU_SEL_MULT, 6'd30, 6'd10, 4'b0011);
        @(negedge clk); endc();
        rob_br_pred_correct_i = 1'b1; rob_br_tag_fix_i = 4'b0001;
        issue(`FU_SEL_ALU, 6'd31, 6'd11, 4'b0001);
        @(negedge clk); endc();
        @(negedge clk); lit_cdb("corr_alu", 1'b1, 31, 0); endc();
        @(negedge clk); lit_cdb("corr_gap", 1'b0, 0, 0); endc();
        @(negedge clk); lit_cdb("corr_mult", 1'b1, 30, 2); endc();

        // Back-to-back mixed latencies, an undefined code and a NONE bundle
        for (int k = 0; k < 8; k++) begin
            case (k)
                0: issue(`FU_SEL_COND_BRANCH, 6'd40, 6'd12, 4'b0);
                1: issue(`FU_SEL_STORE, 6'd41, 6'd13, 4'b0);
                2: issue(3'd7, 6'd42, 6'd14, 4'b0);
                3: issue(`FU_SEL_UNCOND_BRANCH, 6'd43, 6'd15, 4'b0);
                4: issue(`FU_SEL_NONE, 6'd44, 6'd16, 4'b0);
                default: quiet();
            endcase
            @(negedge clk);
            case (k)
                1: lit_cdb("b2b_br", 1'b1, 40, 0);
                2: lit_cdb("b2b_st", 1'b1, 41, 0);
                4: lit_cdb("b2b_ubr", 1'b1, 43, 0);
                5: check("b2b_inflight", 32'(inflight_o), 1);
                6: lit_cdb("b2b_undef", 1'b1, 42, 0);
                7: lit_cdb("b2b_none", 1'b0, 0, 0);
                default: ;
            endcase
            endc();
        end

        // Reset with three ops in flight
        issue(`FU_SEL_MULT, 6'd50, 6'd17, 4'b0);
        @(negedge clk); endc();
        issue(`FU_SEL_MULT, 6'd51, 6'd18, 4'b0);
        @(negedge clk); endc();
        issue(`FU_SEL_MULT, 6'd52, 6'd19, 4'b0);
        @(negedge clk); endc();
        rst = 1'b1;
        @(negedge clk); check("midrst_inflight3", 32'(inflight_o), 3); endc();
        rst = 1'b0;
        @(negedge clk);
        lit_cdb("midrst_vld", 1'b0, 0, 0);
        check("midrst_tag", 32'(cdb_tag_o), 0);
        check("midrst_rob", 32'(cdb_rob_idx_o), 0);
        check("midrst_mask", 32'(cdb_br_mask_o), 0);
        check("midrst_inflight", 32'(inflight_o), 0);
        endc();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); lit_cdb("midrst_quiet", 1'b0, 0, 0); endc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
